// File: rtl/mcs4_rom_responder.sv
// MCS-4 style ROM chip bus responder. It follows the 8-phase instruction cycle,
// serves opcode fetches from an external ROM array and handles WRR/RDR port I/O.
module mcs4_rom_responder #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       SYNC_N,
    input  logic       CM_ROM_N,
    input  logic [3:0] DATA_I,
    output logic [3:0] DATA_O,
    output logic       DATA_OE,
    output logic [7:0] ROM_ADDR,
    input  logic [7:0] ROM_DATA,
    input  logic [3:0] IO_I,
    output logic [3:0] IO_O
);

    typedef enum logic [3:0] {
        UNSYNC, A1, A2, A3, M1, M2, X1, X2, X3
    } phase_t;

    localparam logic [3:0] OPR_IO  = 4'hE;
    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;

    phase_t     phase;
    phase_t     phase_next;
    logic [7:0] instr;
    logic       rom_sel;
    logic       io_sel;
    logic [3:0] bus_opr;
    logic       wr_pend;
    logic       rd_pend;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) phase <= UNSYNC;
        else     phase <= phase_next;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves it unassigned and infers a latch.
    always_comb begin
        phase_next = phase;
        if (!SYNC_N) begin
            phase_next = A1;
        end else begin
            case (phase)
                A1:      phase_next = A2;
                A2:      phase_next = A3;
                A3:      phase_next = M1;
                M1:      phase_next = M2;
                M2:      phase_next = X1;
                X1:      phase_next = X2;
                X2:      phase_next = X3;
                X3:      phase_next = A1;
                default: phase_next = UNSYNC;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples
    // the pre-edge values regardless of statement order inside the block.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ROM_ADDR <= 8'h00;
            instr    <= 8'h00;
            rom_sel  <= 1'b0;
            io_sel   <= 1'b0;
            bus_opr  <= 4'h0;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            IO_O     <= 4'h0;
        end else begin
            case (phase)
                A1: ROM_ADDR[3:0] <= DATA_I;
                A2: ROM_ADDR[7:4] <= DATA_I;
                A3: begin
                    rom_sel <= !CM_ROM_N && (DATA_I == CHIP_ID);
                    instr   <= ROM_DATA;
                end
                // Every chip snoops the opcode nibble, selected or not.
                M1: bus_opr <= DATA_I;
                M2: begin
                    if (!CM_ROM_N && (bus_opr == OPR_IO) && io_sel) begin
                        wr_pend <= (DATA_I == OPA_WRR);
                        rd_pend <= (DATA_I == OPA_RDR);
                    end
                end
                // A pending port command owns X2; SRC is only decoded otherwise.
                X2: begin
                    if (wr_pend)
                        IO_O <= DATA_I;
                    else if (!rd_pend && !CM_ROM_N)
                        io_sel <= (DATA_I == CHIP_ID);
                end
                default: ;
            endcase
            if (phase == X3 || !SYNC_N) begin
                wr_pend <= 1'b0;
                rd_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        DATA_OE = 1'b0;
        DATA_O  = 4'h0;
        case (phase)
            M1: begin
                if (rom_sel) begin
                    DATA_OE = 1'b1;
                    DATA_O  = instr[7:4];
                end
            end
            M2: begin
                if (rom_sel) begin
                    DATA_OE = 1'b1;
                    DATA_O  = instr[3:0];
                end
            end
            X2: begin
                if (rd_pend) begin
                    DATA_OE = 1'b1;
                    DATA_O  = IO_I;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mcs4_rom_responder.sv
// Randomised instruction-cycle bench for mcs4_rom_responder with an
// instruction-level reference model feeding a per-cycle scoreboard.
module tb_mcs4_rom_responder;

    localparam logic [3:0] CHIP = 4'h3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sync_n = 1'b1;
    logic       cm_rom_n = 1'b1;
    logic [3:0] bus_drv = 4'h0;
    logic [3:0] io_i = 4'h0;
    logic [3:0] data_i;
    logic [3:0] data_o;
    logic       data_oe;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] io_o;
    logic [7:0] rom [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       oe;
        logic [3:0] dout;
        logic [3:0] io;
        logic [7:0] addr;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state, updated at instruction granularity.
    logic [7:0] m_addr   = 8'h00;
    logic [3:0] m_io     = 4'h0;
    logic       m_io_sel = 1'b0;

    // The shared bus: the DUT wins when it drives, otherwise the bench does.
    assign data_i   = data_oe ? data_o : bus_drv;
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    mcs4_rom_responder #(.CHIP_ID(CHIP)) dut (
        .CLK      (clk),
        .RES      (rst),
        .SYNC_N   (sync_n),
        .CM_ROM_N (cm_rom_n),
        .DATA_I   (data_i),
        .DATA_O   (data_o),
        .DATA_OE  (data_oe),
        .ROM_ADDR (rom_addr),
        .ROM_DATA (rom_data),
        .IO_I     (io_i),
        .IO_O     (io_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    task automatic drive(input logic s, input logic c, input logic [3:0] d, input logic [3:0] io);
        @(posedge clk);
        #1;
        sync_n   = s;
        cm_rom_n = c;
        bus_drv  = d;
        io_i     = io;
    endtask

    task automatic push_exp(input string tag, input logic oe, input logic [3:0] dout);
        exp_t e;
        e.tag  = tag;
        e.oe   = oe;
        e.dout = dout;
        e.io   = m_io;
        e.addr = m_addr;
        sb_q.push_back(e);
    endtask

    // One full A1..X3 instruction cycle; SYNC_N pulses in X3 to start the next one.
    task automatic run_instr(input logic [7:0] addr, input logic [3:0] chip, input logic cm_a3,
                             input logic [3:0] m1_val, input logic [3:0] m2_val, input logic cm_m2,
                             input logic [3:0] x2_val, input logic cm_x2, input logic [3:0] x2_io);
        logic       sel;
        logic       cmd;
        logic       wr;
        logic       rd;
        logic [7:0] word;
        logic [3:0] b1;
        logic [3:0] b2;
        word = rom[addr];
        sel  = !cm_a3 && (chip == CHIP);
        b1   = sel ? word[7:4] : m1_val;
        b2   = sel ? word[3:0] : m2_val;
        cmd  = !cm_m2 && (b1 == 4'hE) && m_io_sel;
        wr   = cmd && (b2 == 4'h2);
        rd   = cmd && (b2 == 4'hA);

        drive(1'b1, r1(), addr[3:0], r4());
        push_exp("A1", 1'b0, 4'h0);
        m_addr[3:0] = addr[3:0];
        drive(1'b1, r1(), addr[7:4], r4());
        push_exp("A2", 1'b0, 4'h0);
        m_addr = addr;
        drive(1'b1, cm_a3, chip, r4());
        push_exp("A3", 1'b0, 4'h0);
        drive(1'b1, r1(), m1_val, r4());
        push_exp("M1", sel, sel ? b1 : 4'h0);
        drive(1'b1, cm_m2, m2_val, r4());
        push_exp("M2", sel, sel ? b2 : 4'h0);
        drive(1'b1, r1(), r4(), r4());
        push_exp("X1", 1'b0, 4'h0);
        drive(1'b1, cm_x2, x2_val, x2_io);
        push_exp("X2", rd, rd ? x2_io : 4'h0);
        if (wr)
            m_io = x2_val;
        else if (!rd && !cm_x2)
            m_io_sel = (x2_val == CHIP);
        drive(1'b0, r1(), r4(), r4());
        push_exp("X3", 1'b0, 4'h0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, " data_oe"}, 32'(data_oe), 32'(e.oe));
            check({e.tag, " data_o"}, 32'(data_o), 32'(e.dout));
            check({e.tag, " io_o"}, 32'(io_o), 32'(e.io));
            check({e.tag, " rom_addr"}, 32'(rom_addr), 32'(e.addr));
        end
    end

    initial begin
        logic [7:0] addr;
        logic [3:0] chip;
        logic [3:0] m1;
        logic [3:0] m2;
        logic [3:0] x2;

        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 7))
                0:       rom[i] = 8'hE2;
                1:       rom[i] = 8'hEA;
                2:       rom[i] = 8'hE1;
                default: rom[i] = 8'($urandom);
            endcase
        end
        rom[8'h5A] = 8'hD7;
        rom[8'h77] = 8'hB6;

        // Reset must act before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("reset_async data_oe", 32'(data_oe), 32'(1'b0));
        check("reset_async data_o", 32'(data_o), 32'(4'h0));
        check("reset_async io_o", 32'(io_o), 32'(4'h0));
        check("reset_async rom_addr", 32'(rom_addr), 32'(8'h00));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // UNSYNC: nothing loads or drives until SYNC_N.
        repeat (3) begin
            drive(1'b1, 1'b0, CHIP, r4());
            @(negedge clk);
            check("unsync data_oe", 32'(data_oe), 32'(1'b0));
            check("unsync rom_addr", 32'(rom_addr), 32'(8'h00));
        end
        drive(1'b0, 1'b1, r4(), r4());

        // Selected fetch of ROM[5A]=D7, then the same fetch aimed at chip 4.
        run_instr(8'h5A, CHIP, 1'b0, r4(), r4(), 1'b1, r4(), 1'b1, r4());
        check("fetch_sel rom_addr", 32'(rom_addr), 32'(8'h5A));
        run_instr(8'h5A, 4'h4, 1'b0, 4'h1, 4'h1, 1'b1, r4(), 1'b1, r4());
        check("fetch_other rom_addr", 32'(rom_addr), 32'(8'h5A));

        // SRC to this chip, then WRR 9 with CM low in X2 (I/O must win over SRC).
        run_instr(8'h20, 4'h4, 1'b0, 4'h2, 4'h1, 1'b0, CHIP, 1'b0, r4());
        run_instr(8'h21, 4'h4, 1'b0, 4'hE, 4'h2, 1'b0, 4'h9, 1'b0, r4());
        check("wrr io_o", 32'(io_o), 32'(4'h9));
        run_instr(8'h22, 4'h4, 1'b0, 4'hE, 4'hA, 1'b0, 4'h5, 1'b0, 4'hC);
        check("rdr io_o unchanged", 32'(io_o), 32'(4'h9));
        run_instr(8'h23, 4'h4, 1'b0, 4'hE, 4'h1, 1'b0, 4'h6, 1'b1, 4'hC);
        check("opa1 io_o unchanged", 32'(io_o), 32'(4'h9));

        // Resync in M1 of a selected fetch.
        drive(1'b1, 1'b1, 4'hA, r4());
        drive(1'b1, 1'b1, 4'h5, r4());
        drive(1'b1, 1'b0, CHIP, r4());
        drive(1'b0, 1'b1, r4(), r4());
        @(negedge clk);
        check("resync_m1 data_oe", 32'(data_oe), 32'(1'b1));
        check("resync_m1 data_o", 32'(data_o), 32'(4'hD));
        drive(1'b1, 1'b0, 4'h6, r4());
        @(negedge clk);
        check("resync_a1 data_oe", 32'(data_oe), 32'(1'b0));
        check("resync_a1 data_o", 32'(data_o), 32'(4'h0));
        drive(1'b1, 1'b1, 4'h1, r4());
        @(negedge clk);
        check("resync_a2 rom_addr", 32'(rom_addr), 32'(8'h56));
        drive(1'b0, 1'b1, r4(), r4());
        @(negedge clk);
        check("resync_a3 rom_addr", 32'(rom_addr), 32'(8'h16));
        m_addr = 8'h16;

        // Randomised instruction cycles.
        for (int n = 0; n < 300; n++) begin
            addr = 8'($urandom);
            chip = r1() ? CHIP : r4();
            m1   = r1() ? 4'hE : r4();
            case ($urandom_range(0, 2))
                0:       m2 = 4'h2;
                1:       m2 = 4'hA;
                default: m2 = r4();
            endcase
            x2 = r1() ? CHIP : r4();
            run_instr(addr, chip, ($urandom_range(0, 3) == 0), m1, m2,
                      ($urandom_range(0, 3) == 0), x2, r1(), r4());
        end

        // Reset pulsed between edges during a selected M2 with IO_O nonzero.
        run_instr(8'h30, 4'h4, 1'b0, 4'h2, 4'h1, 1'b0, CHIP, 1'b0, r4());
        run_instr(8'h31, 4'h4, 1'b0, 4'hE, 4'h2, 1'b0, 4'hF, 1'b1, r4());
        check("pre_reset io_o", 32'(io_o), 32'(4'hF));
        drive(1'b1, 1'b1, 4'h7, r4());
        drive(1'b1, 1'b1, 4'h7, r4());
        drive(1'b1, 1'b0, CHIP, r4());
        drive(1'b1, 1'b1, r4(), r4());
        drive(1'b1, 1'b1, r4(), r4());
        #1;
        check("pre_reset m2 data_oe", 32'(data_oe), 32'(1'b1));
        check("pre_reset m2 data_o", 32'(data_o), 32'(4'h6));
        rst = 1'b1;
        #1;
        check("mid_reset data_oe", 32'(data_oe), 32'(1'b0));
        check("mid_reset data_o", 32'(data_o), 32'(4'h0));
        check("mid_reset io_o", 32'(io_o), 32'(4'h0));
        check("mid_reset rom_addr", 32'(rom_addr), 32'(8'h00));
        rst = 1'b0;
        m_addr   = 8'h00;
        m_io     = 4'h0;
        m_io_sel = 1'b0;
        repeat (20) begin
            drive(1'b1, r1(), r4(), r4());
            @(negedge clk);
            check("post_reset data_oe", 32'(data_oe), 32'(1'b0));
            check("post_reset rom_addr", 32'(rom_addr), 32'(8'h00));
        end
        drive(1'b0, 1'b1, r4(), r4());
        for (int n = 0; n < 30; n++) begin
            run_instr(8'($urandom), r1() ? CHIP : r4(), r1(), r1() ? 4'hE : r4(),
                      r1() ? 4'h2 : 4'hA, r1(), r1() ? CHIP : r4(), r1(), r4());
        end

        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
